dp_ram_ctrl: RTL
================

Name: dp_ram_ctrl

Overview:
- Sequencer and arbiter in front of the dual-port SRAM wrapper.
- After reset, it zero-initialises every RAM entry through the write port (port B).
- It then round-robin-shares read port A among NUM_RD requesters and write port B among NUM_WR requesters.
- Read responses return one cycle after the request is accepted, tagged with the requester id. Both RAM ports are driven from CLKA; the integrator ties the RAM's CLKB to CLKA.

Parameters:
- ADDR_WIDTH, 6, RAM address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, RAM word width.
- NUM_RD, 2, number of read requesters (>=1).
- NUM_WR, 2, number of write requesters (>=1).
- INIT_EN, 1, 1 = zero-fill RAM after reset; 0 = go straight to RUN.

Ports:
- CLKA  in  1  clock, used for both RAM ports
- rst_n  in  1  synchronous, active-low reset, sampled on CLKA
- init_done  out  1  1 once zero-fill has completed
- rd_req_valid  in  NUM_RD  per-requester read request
- rd_req_addr  in  NUM_RD*ADDR_WIDTH  packed read addresses; requester i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd_req_ready  out  NUM_RD  read grant; one-hot or zero
- rd_rsp_valid  out  1  read data valid
- rd_rsp_id  out  max(1,$clog2(NUM_RD))  id of the requester that owns rd_rsp_data
- rd_rsp_data  out  DATA_WIDTH  read data
- wr_req_valid  in  NUM_WR  per-requester write request
- wr_req_addr  in  NUM_WR*ADDR_WIDTH  packed write addresses
- wr_req_data  in  NUM_WR*DATA_WIDTH  packed write data
- wr_req_mask  in  NUM_WR*DATA_WIDTH  packed bit-enables; 1 = write bit
- wr_req_ready  out  NUM_WR  write grant; one-hot or zero
- ram_aa  out  ADDR_WIDTH  RAM port A address
- ram_cea  out  1  RAM port A read enable
- ram_ab  out  ADDR_WIDTH  RAM port B address
- ram_ceb  out  1  RAM port B write enable
- ram_db  out  DATA_WIDTH  RAM port B write data
- ram_bwb  out  DATA_WIDTH  RAM port B bit-enable
- ram_qa  in  DATA_WIDTH  RAM port A read data; valid one cycle after ram_cea

Behaviour:
- Reset: rst_n is synchronous and active-low, clocked on CLKA. It applies at any time, including mid-init or mid-traffic.
  - Registers: state=INIT (RUN if INIT_EN=0), init_cnt=0, both round-robin pointers=0, rd_rsp_valid=0, rd_rsp_id=0, init_done=0 (1 if INIT_EN=0).
  - While rst_n=0 all outputs are gated: ram_cea=ram_ceb=0, rd_req_ready=wr_req_ready=0, rd_rsp_valid=0, init_done=0.
  - A reset asserted during INIT restarts the fill from address 0.
  - A read accepted in the cycle reset is sampled produces no response.
- FSM states: INIT, RUN.
  - INIT: each cycle drives ram_ceb=1, ram_ab=init_cnt, ram_db=0, ram_bwb=all ones; init_cnt increments.
  - INIT: ram_cea=0 and all readies are 0.
  - INIT ends on the cycle init_cnt = 2**ADDR_WIDTH-1; the next state is RUN. Fill takes exactly 2**ADDR_WIDTH cycles.
  - init_cnt must not wrap into a second pass.
  - init_done is registered: it rises on the first RUN cycle and stays 1 until reset.
  - RUN is absorbing; there is no exit except reset.
- RUN arbitration. Read and write arbiters are independent and share no state.
  - Requester priority starts at the index held in the pointer, searching upward with wrap.
  - The first valid requester wins and its ready is asserted in the same cycle (ready is a combinational function of valid and the pointer).
  - On a grant, pointer <= winner+1 mod N. With no valid requester the pointer holds.
  - A requester must hold valid and its payload stable until it sees ready.
- Read path:
  - On a grant: ram_cea=1, ram_aa=winner's address.
  - Next cycle: rd_rsp_valid=1, rd_rsp_id=registered winner, rd_rsp_data=ram_qa.
  - No backpressure: a response is produced every cycle a read was granted, giving back-to-back throughput of 1 read/cycle.
  - Consumers must accept a response whenever rd_rsp_valid=1.
- Write path:
  - On a grant: ram_ceb=1, ram_ab, ram_db and ram_bwb are taken from the winner's slice.
  - Writes complete in the RAM at that edge and produce no response.
- Same-cycle read and write to one address: both are issued.
  - The RAM wrapper bypasses the write, so rd_rsp_data equals (old & ~mask) | (new & mask).
  - The controller adds no stall or hazard logic.
- When ram_cea=0 or ram_ceb=0, the corresponding address/data outputs are don't-care. Implementations drive them to 0 to limit toggling.
- Width rules:
  - Pointer width is $clog2(N); when N=1 the pointer is tied to 0.
  - Wrap uses explicit compare-to-(N-1), never natural overflow, so N need not be a power of two.

Decomposition:
- Package dp_ram_ctrl_pkg holds:
  - the state typedef enum {INIT, RUN};
  - a function for the id width, max(1,$clog2(n)).
- Sub-module rr_arbiter #(N) contains the pointer register and the grant logic.
  - Ports: clk, rst_n, req[N], gnt[N] (one-hot), gnt_idx, gnt_valid.
  - Instantiated once for reads and once for writes, with grants gated off while state=INIT.

Test Plan (ADDR_WIDTH=4, DATA_WIDTH=32, NUM_RD=2, NUM_WR=2):
- Release reset -> ram_ceb=1 for exactly 16 cycles with ram_ab=0..15 and ram_db=0; init_done=1 on cycle 17; no readies during the fill. Reading all 16 addresses afterwards returns 0.
- Write req0: addr 5, data 0xDEADBEEF, mask all ones. Next cycle read req1 addr 5 -> rd_rsp_valid one cycle after grant, rd_rsp_id=1, data 0xDEADBEEF.
- Both readers valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; six responses with matching ids on consecutive cycles.
- Addr 3 holds 0x11111111. Same cycle: write addr 3, data 0xFFFFFFFF, mask 0x0000FFFF, and read addr 3 -> response 0x1111FFFF.
- Assert rst_n=0 at init_cnt=7 for 1 cycle -> fill restarts at address 0 and runs 16 more cycles; init_done stays 0 until it completes.
- Pending read granted in the same cycle rst_n=0 is sampled -> no rd_rsp_valid afterwards; both pointers back at 0 (requester 0 wins first when both are valid).

Source files
------------

// File: rtl/dp_ram_ctrl_pkg.sv
// Shared types and helpers for the dual-port RAM sequencer/arbiter.
package dp_ram_ctrl_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Width of a requester id / pointer; never below one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dp_ram_ctrl_if.sv
// Requester-side and RAM-side signal bundle for dp_ram_ctrl.
interface dp_ram_ctrl_if
  import dp_ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned NUM_WR     = 2
);
  localparam int unsigned RIW = id_width(NUM_RD);

  logic [NUM_RD-1:0]            rd_req_valid;
  logic [NUM_RD*ADDR_WIDTH-1:0] rd_req_addr;
  logic [NUM_RD-1:0]            rd_req_ready;
  logic                         rd_rsp_valid;
  logic [RIW-1:0]               rd_rsp_id;
  logic [DATA_WIDTH-1:0]        rd_rsp_data;

  logic [NUM_WR-1:0]            wr_req_valid;
  logic [NUM_WR*ADDR_WIDTH-1:0] wr_req_addr;
  logic [NUM_WR*DATA_WIDTH-1:0] wr_req_data;
  logic [NUM_WR*DATA_WIDTH-1:0] wr_req_mask;
  logic [NUM_WR-1:0]            wr_req_ready;

  logic [ADDR_WIDTH-1:0]        ram_aa;
  logic                         ram_cea;
  logic [ADDR_WIDTH-1:0]        ram_ab;
  logic                         ram_ceb;
  logic [DATA_WIDTH-1:0]        ram_db;
  logic [DATA_WIDTH-1:0]        ram_bwb;
  logic [DATA_WIDTH-1:0]        ram_qa;

  // Controller side.
  modport slave (
    input  rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_data, wr_req_mask, ram_qa,
    output rd_req_ready, rd_rsp_valid, rd_rsp_id, rd_rsp_data, wr_req_ready,
    output ram_aa, ram_cea, ram_ab, ram_ceb, ram_db, ram_bwb
  );

  // Requesters plus RAM, seen from outside the controller.
  modport master (
    output rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_data, wr_req_mask, ram_qa,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_id, rd_rsp_data, wr_req_ready,
    input  ram_aa, ram_cea, ram_ab, ram_ceb, ram_db, ram_bwb
  );

endinterface

// File: rtl/dp_ram_ctrl_rr_arbiter.sv
// Round-robin arbiter: pointer register plus combinational one-hot grant.
module rr_arbiter
  import dp_ram_ctrl_pkg::*;
#(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = id_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  logic [IW-1:0] ptr_q, ptr_d;
  int unsigned   idx;

  // Search upward from the pointer with explicit wrap; first requester wins.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!gnt_valid && req[IW'(idx)]) begin
        gnt_valid        = 1'b1;
        gnt_idx          = IW'(idx);
        gnt[IW'(idx)]    = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_valid) ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dp_ram_ctrl.sv
// Zero-fills the dual-port RAM after reset, then round-robin shares the read
// port among NUM_RD requesters and the write port among NUM_WR requesters.
module dp_ram_ctrl
  import dp_ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned NUM_WR     = 2,
  parameter int unsigned INIT_EN    = 1
) (
  input  logic          CLKA,
  input  logic          rst_n,
  output logic          init_done,
  dp_ram_ctrl_if.slave  bus
);

  localparam int unsigned RIW = id_width(NUM_RD);
  localparam int unsigned WIW = id_width(NUM_WR);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam state_e RST_STATE = (INIT_EN != 0) ? INIT : RUN;
  localparam logic   RST_DONE  = (INIT_EN != 0) ? 1'b0 : 1'b1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  init_done_q, init_done_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [RIW-1:0]        rsp_id_q, rsp_id_d;

  logic                  run_c;
  logic [NUM_RD-1:0]     rd_req_g, rd_gnt;
  logic [NUM_WR-1:0]     wr_req_g, wr_gnt;
  logic [RIW-1:0]        rd_gnt_idx;
  logic [WIW-1:0]        wr_gnt_idx;
  logic                  rd_gnt_valid, wr_gnt_valid;

  // No grants during the fill or while reset is held.
  assign run_c    = (state_q == RUN) && rst_n;
  assign rd_req_g = bus.rd_req_valid & {NUM_RD{run_c}};
  assign wr_req_g = bus.wr_req_valid & {NUM_WR{run_c}};

  rr_arbiter #(.N(NUM_RD)) u_rd_arb (
    .clk       (CLKA),
    .rst_n     (rst_n),
    .req       (rd_req_g),
    .gnt       (rd_gnt),
    .gnt_idx   (rd_gnt_idx),
    .gnt_valid (rd_gnt_valid)
  );

  rr_arbiter #(.N(NUM_WR)) u_wr_arb (
    .clk       (CLKA),
    .rst_n     (rst_n),
    .req       (wr_req_g),
    .gnt       (wr_gnt),
    .gnt_idx   (wr_gnt_idx),
    .gnt_valid (wr_gnt_valid)
  );

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    rsp_valid_d = rd_gnt_valid;
    rsp_id_d    = rd_gnt_valid ? rd_gnt_idx : rsp_id_q;
    bus.ram_cea = 1'b0;
    bus.ram_aa  = '0;
    bus.ram_ceb = 1'b0;
    bus.ram_ab  = '0;
    bus.ram_db  = '0;
    bus.ram_bwb = '0;
    case (state_q)
      INIT: begin
        bus.ram_ceb = rst_n;
        bus.ram_ab  = init_cnt_q;
        bus.ram_bwb = {DATA_WIDTH{rst_n}};
        if (init_cnt_q == LAST_ADDR) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end else begin
          init_cnt_d  = init_cnt_q + ADDR_WIDTH'(1);
        end
      end
      RUN: begin
        if (rd_gnt_valid) begin
          bus.ram_cea = 1'b1;
          bus.ram_aa  = bus.rd_req_addr[32'(rd_gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        end
        if (wr_gnt_valid) begin
          bus.ram_ceb = 1'b1;
          bus.ram_ab  = bus.wr_req_addr[32'(wr_gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          bus.ram_db  = bus.wr_req_data[32'(wr_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
          bus.ram_bwb = bus.wr_req_mask[32'(wr_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    endcase
  end

  always_ff @(posedge CLKA) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      init_cnt_q  <= '0;
      init_done_q <= RST_DONE;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  // RAM read data is already registered inside the RAM; forward it directly.
  assign bus.rd_req_ready = rd_gnt;
  assign bus.wr_req_ready = wr_gnt;
  assign bus.rd_rsp_valid = rsp_valid_q & rst_n;
  assign bus.rd_rsp_id    = rsp_id_q;
  assign bus.rd_rsp_data  = bus.ram_qa;
  assign init_done        = init_done_q & rst_n;

endmodule
